// File: rtl/dcmi_capture_ctrl_pkg.sv
// Shared definitions for the ZX-to-DCMI capture path: FSM encoding,
// default window geometry and the DCMI byte layout.
package dcmi_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_FRAME = 2'd2,
    ST_END   = 2'd3
  } cap_state_e;

  localparam int DEF_CNT_W    = 10;
  localparam int DEF_H_START  = 96;
  localparam int DEF_H_WIDTH  = 320;
  localparam int DEF_V_START  = 24;
  localparam int DEF_V_HEIGHT = 240;

  // DCMI byte carries the ZX colour nibble {I,B,G,R} in the low bits.
  function automatic logic [7:0] dcmi_byte(input logic [3:0] rgbi);
    return {4'b0000, rgbi};
  endfunction

endpackage

// File: rtl/dcmi_capture_ctrl_zx_sync_counter.sv
// ZX raster position tracker: registers HS/VS once, detects falling edges
// and maintains saturating pixel (h_cnt) and line (v_cnt) counters.
module zx_sync_counter #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hs,
  input  logic             vs,
  output logic             hs_fall,
  output logic             vs_fall,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic hs_q;
  logic vs_q;

  assign hs_fall = hs_q & ~hs;
  assign vs_fall = vs_q & ~vs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      hs_q <= hs;
      vs_q <= vs;
      if (hs_fall)
        h_cnt <= '0;
      else if (h_cnt != CNT_MAX)
        h_cnt <= h_cnt + 1'b1;
      // A frame start wins over the line start that usually coincides with it.
      if (vs_fall)
        v_cnt <= '0;
      else if (hs_fall && (v_cnt != CNT_MAX))
        v_cnt <= v_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dcmi_capture_ctrl.sv
// Frame-capture sequencer: crops a window out of the ZX raster and drives
// registered DCMI data/valid strobes, single-shot or continuous.
module dcmi_capture_ctrl
  import dcmi_capture_ctrl_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int H_START  = DEF_H_START,
  parameter int H_WIDTH  = DEF_H_WIDTH,
  parameter int V_START  = DEF_V_START,
  parameter int V_HEIGHT = DEF_V_HEIGHT
) (
  input  logic       ZX_PIX_CLK,
  input  logic       ZX_RST_N,
  input  logic [3:0] ZX_RGBI,
  input  logic       ZX_HS,
  input  logic       ZX_VS,
  input  logic       CAP_REQ,
  input  logic       CAP_CONT,
  output logic [7:0] DCMI_DATA,
  output logic       DCMI_HSYNC,
  output logic       DCMI_VSYNC,
  output logic       CAP_BUSY,
  output logic       CAP_DONE,
  output logic       CAP_ERR,
  output logic [7:0] FRAME_CNT,
  output cap_state_e dbg_state
);

  localparam logic [CNT_W:0] H_LO   = (CNT_W+1)'(H_START);
  localparam logic [CNT_W:0] H_HI   = (CNT_W+1)'(H_START + H_WIDTH);
  localparam logic [CNT_W:0] V_LO   = (CNT_W+1)'(V_START);
  localparam logic [CNT_W:0] V_HI   = (CNT_W+1)'(V_START + V_HEIGHT);
  localparam logic [CNT_W:0] V_LAST = (CNT_W+1)'(V_START + V_HEIGHT - 1);

  logic             hs_fall;
  logic             vs_fall;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [3:0]       rgbi_q;
  cap_state_e       state;
  cap_state_e       state_nx;
  logic             err_set;
  logic             err_clr;
  logic             in_h;
  logic             in_v;
  logic             frame_last;
  logic             win_v;
  logic             win_hv;

  zx_sync_counter #(.CNT_W(CNT_W)) u_sync (
    .clk     (ZX_PIX_CLK),
    .rst_n   (ZX_RST_N),
    .hs      (ZX_HS),
    .vs      (ZX_VS),
    .hs_fall (hs_fall),
    .vs_fall (vs_fall),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt)
  );

  assign in_h = ({1'b0, h_cnt} >= H_LO) && ({1'b0, h_cnt} < H_HI);
  assign in_v = ({1'b0, v_cnt} >= V_LO) && ({1'b0, v_cnt} < V_HI);
  // This line start moves v_cnt past the last window line.
  assign frame_last = hs_fall && !vs_fall && ({1'b0, v_cnt} == V_LAST);
  assign win_v  = (state == ST_FRAME) && in_v;
  assign win_hv = win_v && in_h;

  assign CAP_BUSY  = (state == ST_SYNC) || (state == ST_FRAME);
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    err_set  = 1'b0;
    err_clr  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (CAP_REQ) begin
          state_nx = ST_SYNC;
          err_clr  = 1'b1;
        end
      end
      ST_SYNC: begin
        if (vs_fall) state_nx = ST_FRAME;
      end
      ST_FRAME: begin
        if (vs_fall) begin
          state_nx = ST_SYNC;
          err_set  = 1'b1;
        end else if (frame_last) begin
          state_nx = ST_END;
        end
      end
      ST_END: begin
        state_nx = (CAP_CONT && CAP_REQ) ? ST_SYNC : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge ZX_PIX_CLK or negedge ZX_RST_N) begin
    if (!ZX_RST_N) begin
      state      <= ST_IDLE;
      rgbi_q     <= 4'h0;
      DCMI_DATA  <= 8'h00;
      DCMI_HSYNC <= 1'b0;
      DCMI_VSYNC <= 1'b0;
      CAP_DONE   <= 1'b0;
      CAP_ERR    <= 1'b0;
      FRAME_CNT  <= 8'h00;
    end else begin
      state      <= state_nx;
      rgbi_q     <= ZX_RGBI;
      DCMI_VSYNC <= win_v;
      DCMI_HSYNC <= win_hv;
      DCMI_DATA  <= win_hv ? dcmi_byte(rgbi_q) : 8'h00;
      CAP_DONE   <= (state == ST_END);
      if (state == ST_END)
        FRAME_CNT <= FRAME_CNT + 8'd1;
      if (err_set)
        CAP_ERR <= 1'b1;
      else if (err_clr)
        CAP_ERR <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dcmi_capture_ctrl.sv
// Bench for dcmi_capture_ctrl on a shrunken ZX raster (16 px x 9 lines,
// window 8x4 at (4,2)) so that long multi-frame runs stay short.
module tb_dcmi_capture_ctrl;
  import dcmi_capture_ctrl_pkg::*;

  localparam int LINE      = 16;
  localparam int LINES     = 9;
  localparam int HS_LOW    = 2;
  localparam int H_START   = 4;
  localparam int H_WIDTH   = 8;
  localparam int V_START   = 2;
  localparam int V_HEIGHT  = 4;
  localparam int FRAME_CYC = LINE * LINES;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] zx_rgbi;
  logic       zx_hs;
  logic       zx_vs;
  logic       cap_req;
  logic       cap_cont;
  logic [7:0] dcmi_data;
  logic       dcmi_hsync;
  logic       dcmi_vsync;
  logic       cap_busy;
  logic       cap_done;
  logic       cap_err;
  logic [7:0] frame_cnt;
  cap_state_e dbg_state;

  dcmi_capture_ctrl #(
    .CNT_W(10), .H_START(H_START), .H_WIDTH(H_WIDTH),
    .V_START(V_START), .V_HEIGHT(V_HEIGHT)
  ) dut (
    .ZX_PIX_CLK (clk),
    .ZX_RST_N   (rst_n),
    .ZX_RGBI    (zx_rgbi),
    .ZX_HS      (zx_hs),
    .ZX_VS      (zx_vs),
    .CAP_REQ    (cap_req),
    .CAP_CONT   (cap_cont),
    .DCMI_DATA  (dcmi_data),
    .DCMI_HSYNC (dcmi_hsync),
    .DCMI_VSYNC (dcmi_vsync),
    .CAP_BUSY   (cap_busy),
    .CAP_DONE   (cap_done),
    .CAP_ERR    (cap_err),
    .FRAME_CNT  (frame_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // monitor counters
  int hs_cyc, vs_cyc, done_cnt, bad_pix, busy_cyc, idle_cyc;

  // raster generator state
  int gpx = 0, gln = 1, cur_ln = 0, inj_line = -1;
  int h0_px = 0, h0_ln = 0, h1_px = 0, h1_ln = 0;
  logic [3:0] h0_rgbi = 4'h0, h1_rgbi = 4'h0;

  typedef struct {
    logic       cont;
    int         frames;
    int         exp_done;
    logic [7:0] exp_fcnt;
    int         exp_hs;
    int         exp_vs;
  } vec_t;
  vec_t vecs[3];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    hs_cyc = 0; vs_cyc = 0; done_cnt = 0; bad_pix = 0; busy_cyc = 0; idle_cyc = 0;
  endtask

  task automatic wait_busy(input string name, input int budget);
    int n = 0;
    while (!cap_busy && n < budget) begin tick(); n++; end
    check(name, int'(n < budget), 1);
  endtask

  task automatic wait_done(input string name, input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin tick(); n++; end
    check(name, int'(n < budget), 1);
  endtask

  task automatic wait_ln(input string name, input int target, input int budget);
    int n = 0;
    while (cur_ln != target && n < budget) begin tick(); n++; end
    check(name, int'(n < budget), 1);
  endtask

  task automatic wait_state(input string name, input cap_state_e st, input int budget);
    int n = 0;
    while (dbg_state != st && n < budget) begin tick(); n++; end
    check(name, int'(n < budget), 1);
  endtask

  // Raster generator plus scoreboard: outputs are sampled first (they reflect
  // the pixel driven two negedges earlier), then the next pixel is driven.
  initial begin
    zx_hs = 1'b1; zx_vs = 1'b1; zx_rgbi = 4'h0;
    forever begin
      @(negedge clk);
      hs_cyc   += int'(dcmi_hsync);
      vs_cyc   += int'(dcmi_vsync);
      done_cnt += int'(cap_done);
      busy_cyc += int'(cap_busy);
      idle_cyc += int'(!cap_busy);
      if (dcmi_hsync) begin
        if (!(h1_px >= H_START && h1_px < H_START + H_WIDTH &&
              h1_ln >= V_START && h1_ln < V_START + V_HEIGHT) ||
            dcmi_data != {4'b0000, h1_rgbi} || !dcmi_vsync)
          bad_pix++;
      end else if (dcmi_data != 8'h00) begin
        bad_pix++;
      end
      if (dcmi_vsync && !(h1_ln >= V_START && h1_ln < V_START + V_HEIGHT))
        bad_pix++;
      h1_px = h0_px; h1_ln = h0_ln; h1_rgbi = h0_rgbi;
      zx_hs   = (gpx >= HS_LOW);
      zx_vs   = (gln != 0);
      zx_rgbi = 4'(gpx + 3 * gln);
      h0_px = gpx; h0_ln = gln; h0_rgbi = zx_rgbi; cur_ln = gln;
      gpx++;
      if (gpx == LINE) begin
        gpx = 0;
        if (inj_line >= 0 && gln == inj_line) begin
          gln = 0;
          inj_line = -1;
        end else if (gln == LINES - 1) begin
          gln = 0;
        end else begin
          gln++;
        end
      end
    end
  end

  initial begin
    vecs[0] = '{cont: 1'b1, frames: 257, exp_done: 257, exp_fcnt: 8'd1, exp_hs: 257*32, exp_vs: 257*64};
    vecs[1] = '{cont: 1'b0, frames: 1,   exp_done: 1,   exp_fcnt: 8'd2, exp_hs: 32,     exp_vs: 64};
    vecs[2] = '{cont: 1'b1, frames: 3,   exp_done: 3,   exp_fcnt: 8'd5, exp_hs: 96,     exp_vs: 192};

    rst_n = 1'b0; cap_req = 1'b0; cap_cont = 1'b0;
    clear_mon();
    repeat (4) tick();
    check("reset_outputs", int'({dcmi_data, dcmi_hsync, dcmi_vsync, cap_busy, cap_done, cap_err, frame_cnt}), 0);
    check("reset_state", int'(dbg_state), int'(ST_IDLE));
    rst_n = 1'b1;
    repeat (3) tick();

    // table-driven captures
    foreach (vecs[i]) begin
      clear_mon();
      cap_cont = vecs[i].cont;
      cap_req  = 1'b1;
      wait_busy($sformatf("v%0d_busy_timeout", i), 4);
      wait_done($sformatf("v%0d_done_timeout_a", i), vecs[i].frames - 1, vecs[i].frames * FRAME_CYC + 2 * FRAME_CYC);
      cap_req = 1'b0;
      wait_done($sformatf("v%0d_done_timeout_b", i), vecs[i].frames, 2 * FRAME_CYC);
      repeat (FRAME_CYC + 20) tick();
      check($sformatf("v%0d_done", i), done_cnt, vecs[i].exp_done);
      check($sformatf("v%0d_frame_cnt", i), int'(frame_cnt), int'(vecs[i].exp_fcnt));
      check($sformatf("v%0d_hsync_cycles", i), hs_cyc, vecs[i].exp_hs);
      check($sformatf("v%0d_vsync_cycles", i), vs_cyc, vecs[i].exp_vs);
      check($sformatf("v%0d_bad_pixels", i), bad_pix, 0);
      check($sformatf("v%0d_state", i), int'(dbg_state), int'(ST_IDLE));
      check($sformatf("v%0d_busy", i), int'(cap_busy), 0);
      check($sformatf("v%0d_err", i), int'(cap_err), 0);
    end

    // request raised mid-frame: wait for next frame start before any VSYNC
    wait_ln("midreq_ln3_timeout", 3, 2 * FRAME_CYC);
    cap_cont = 1'b0;
    cap_req  = 1'b1;
    tick(); tick();
    clear_mon();
    wait_ln("midreq_ln0_timeout", 0, 2 * FRAME_CYC);
    check("midreq_no_vsync", vs_cyc, 0);
    check("midreq_busy_held", idle_cyc, 0);
    cap_req = 1'b0;
    wait_done("midreq_done_timeout", 1, 2 * FRAME_CYC);
    repeat (20) tick();
    check("midreq_hsync_cycles", hs_cyc, 32);
    check("midreq_frame_cnt", int'(frame_cnt), 6);
    check("midreq_bad_pixels", bad_pix, 0);
    check("midreq_state", int'(dbg_state), int'(ST_IDLE));

    // short frame: VS falls again after window line 4 of 2..5
    clear_mon();
    cap_cont = 1'b0;
    cap_req  = 1'b1;
    wait_state("short_frame_timeout", ST_FRAME, 2 * FRAME_CYC);
    cap_req  = 1'b0;
    inj_line = 4;
    wait_ln("short_ln2_timeout", 2, FRAME_CYC);
    wait_ln("short_ln0_timeout", 0, FRAME_CYC);
    repeat (3) tick();
    check("short_err", int'(cap_err), 1);
    check("short_no_done", done_cnt, 0);
    check("short_state_sync", int'(dbg_state), int'(ST_SYNC));
    wait_done("short_done_timeout", 1, 3 * FRAME_CYC);
    repeat (20) tick();
    check("short_done", done_cnt, 1);
    check("short_hsync_cycles", hs_cyc, 24 + 32);
    check("short_frame_cnt", int'(frame_cnt), 7);
    check("short_err_sticky", int'(cap_err), 1);
    check("short_bad_pixels", bad_pix, 0);

    // new request clears the error; then async reset in the middle of a line
    cap_cont = 1'b1;
    cap_req  = 1'b1;
    tick(); tick();
    check("req_clears_err", int'(cap_err), 0);
    wait_state("rst_frame_timeout", ST_FRAME, 2 * FRAME_CYC);
    begin
      int n = 0;
      while (!dcmi_hsync && n < 2 * FRAME_CYC) begin tick(); n++; end
      check("rst_hsync_timeout", int'(n < 2 * FRAME_CYC), 1);
    end
    #2;
    rst_n   = 1'b0;
    cap_req = 1'b0;
    #1;
    check("rst_async_outputs", int'({dcmi_data, dcmi_hsync, dcmi_vsync, cap_busy, cap_done, cap_err, frame_cnt}), 0);
    check("rst_async_state", int'(dbg_state), int'(ST_IDLE));
    repeat (3) tick();
    rst_n = 1'b1;
    clear_mon();
    repeat (2 * FRAME_CYC) tick();
    check("rst_idle_busy", busy_cyc, 0);
    check("rst_idle_hsync", hs_cyc + vs_cyc + done_cnt, 0);
    check("rst_idle_frame_cnt", int'(frame_cnt), 0);
    cap_cont = 1'b0;
    cap_req  = 1'b1;
    wait_busy("rst_recap_busy_timeout", 4);
    cap_req = 1'b0;
    wait_done("rst_recap_done_timeout", 1, 3 * FRAME_CYC);
    repeat (20) tick();
    check("rst_recap_frame_cnt", int'(frame_cnt), 1);
    check("rst_recap_hsync_cycles", hs_cyc, 32);
    check("rst_recap_bad_pixels", bad_pix, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
